// File: rtl/dram_resp.sv
// Memory-side responder for the conv engine: fixed-latency engine reads with
// write forwarding, engine write-backs, and a lower-priority host port.
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  dram_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("dram_resp: RD_LATENCY must be in 1..4");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Engine always wins; at most one write reaches the array per cycle.
  assign host_gnt = host_req & ~dram_en_rd & ~dram_en_wr;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = srstn & (dram_en_wr | (host_gnt & host_we));
    wr_addr = dram_en_wr ? addr_wr : host_addr;
    wr_data = dram_en_wr ? data_wr : host_wdata;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] d,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wd
  );
    return (we && wa == a) ? wd : d;
  endfunction

  // Write-first: a same-cycle write to the read address wins.
  logic [DATA_WIDTH-1:0] rd_fwd;
  assign rd_fwd = fwd(addr_rd, mem[addr_rd], wr_en, wr_addr, wr_data);

  // tail_* is what enters the output register at the end of cycle t+RD_LATENCY-1.
  logic                  tail_vld;
  logic [DATA_WIDTH-1:0] tail_data;

  generate
    if (RD_LATENCY == 1) begin : g_direct
      assign tail_vld  = dram_en_rd;
      assign tail_data = rd_fwd;
    end else begin : g_pipe
      logic [RD_LATENCY-1:1] vld_pipe;
      logic [ADDR_WIDTH-1:0] addr_pipe [1:RD_LATENCY-1];
      logic [DATA_WIDTH-1:0] data_pipe [1:RD_LATENCY-1];

      // Every in-flight stage snoops the current write so later writes land.
      always_ff @(posedge clk) begin
        if (!srstn) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1]  <= dram_en_rd;
          addr_pipe[1] <= addr_rd;
          data_pipe[1] <= rd_fwd;
          for (int s = 2; s < RD_LATENCY; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            addr_pipe[s] <= addr_pipe[s-1];
            data_pipe[s] <= fwd(addr_pipe[s-1], data_pipe[s-1], wr_en, wr_addr, wr_data);
          end
        end
      end

      assign tail_vld  = vld_pipe[RD_LATENCY-1];
      assign tail_data = fwd(addr_pipe[RD_LATENCY-1], data_pipe[RD_LATENCY-1],
                             wr_en, wr_addr, wr_data);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!srstn) begin
      dram_valid <= 1'b0;
      data_rd    <= '0;
    end else begin
      dram_valid <= tail_vld;
      if (tail_vld) data_rd <= tail_data;
    end
  end

  // Host reads never collide with a write: a grant implies the engine is idle.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= mem[host_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (dram_en_rd) rd_count <= rd_count + 32'd1;
      if (dram_en_wr) wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dram_resp.sv
// Bench for dram_resp: drives a latency-1 and a latency-3 instance with the same
// directed stimulus and checks both against a memory/queue model every cycle.
module tb_dram_resp;

  localparam int DW = 32;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic srstn;
  logic rd, wr, hr, hw;
  logic [AW-1:0] ra, wa, ha;
  logic [DW-1:0] wd, hd;

  logic [DW-1:0] d_rd  [2];
  logic          d_vld [2];
  logic          d_gnt [2];
  logic [DW-1:0] d_hrd [2];
  logic          d_hv  [2];
  logic [31:0]   d_rc  [2];
  logic [31:0]   d_wc  [2];

  always #5 clk = ~clk;

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u1 (
    .clk(clk), .srstn(srstn),
    .dram_en_rd(rd), .addr_rd(ra), .dram_en_wr(wr), .addr_wr(wa), .data_wr(wd),
    .data_rd(d_rd[0]), .dram_valid(d_vld[0]),
    .host_req(hr), .host_we(hw), .host_addr(ha), .host_wdata(hd),
    .host_gnt(d_gnt[0]), .host_rdata(d_hrd[0]), .host_rvalid(d_hv[0]),
    .rd_count(d_rc[0]), .wr_count(d_wc[0])
  );

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u3 (
    .clk(clk), .srstn(srstn),
    .dram_en_rd(rd), .addr_rd(ra), .dram_en_wr(wr), .addr_wr(wa), .data_wr(wd),
    .data_rd(d_rd[1]), .dram_valid(d_vld[1]),
    .host_req(hr), .host_we(hw), .host_addr(ha), .host_wdata(hd),
    .host_gnt(d_gnt[1]), .host_rdata(d_hrd[1]), .host_rvalid(d_hv[1]),
    .rd_count(d_rc[1]), .wr_count(d_wc[1])
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          res;   // cycle after whose writes the read value is fixed
    logic [AW-1:0] addr;
  } rd_t;

  logic [DW-1:0] mm [int];
  rd_t           pq [2][$];
  int            lat [2] = '{1, 3};

  logic          e_vld [2];
  logic [DW-1:0] e_data [2];
  logic          e_hv;
  logic [DW-1:0] e_hd;
  logic [31:0]   e_rc, e_wc;
  bit            armed = 0;
  int            cyc = 0;

  function automatic logic [DW-1:0] rdm(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : '0;
  endfunction

  // Mid-cycle: compare this cycle's outputs, then fold in this cycle's inputs
  // to predict the outputs of the next cycle.
  initial begin
    forever begin
      logic gnt;
      @(negedge clk);
      gnt = hr & ~rd & ~wr;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("dram_valid[L%0d]", lat[k]), 32'(d_vld[k]), 32'(e_vld[k]));
          check($sformatf("data_rd[L%0d]", lat[k]), d_rd[k], e_data[k]);
          check($sformatf("host_gnt[L%0d]", lat[k]), 32'(d_gnt[k]), 32'(gnt));
          check($sformatf("host_rvalid[L%0d]", lat[k]), 32'(d_hv[k]), 32'(e_hv));
          check($sformatf("host_rdata[L%0d]", lat[k]), d_hrd[k], e_hd);
          check($sformatf("rd_count[L%0d]", lat[k]), d_rc[k], e_rc);
          check($sformatf("wr_count[L%0d]", lat[k]), d_wc[k], e_wc);
        end
      end
      if (!srstn) begin
        for (int k = 0; k < 2; k++) begin
          pq[k].delete();
          e_vld[k]  = 1'b0;
          e_data[k] = '0;
        end
        e_hv = 1'b0; e_hd = '0; e_rc = '0; e_wc = '0;
        armed = 1;
      end else begin
        if (wr) mm[int'(wa)] = wd;
        else if (gnt && hw) mm[int'(ha)] = hd;
        e_hv = gnt & ~hw;
        if (e_hv) e_hd = rdm(ha);
        if (wr) e_wc++;
        if (rd) e_rc++;
        for (int k = 0; k < 2; k++) begin
          if (rd) pq[k].push_back('{cyc + lat[k] - 1, ra});
          e_vld[k] = 1'b0;
          if (pq[k].size() > 0 && pq[k][0].res == cyc) begin
            e_vld[k]  = 1'b1;
            e_data[k] = rdm(pq[k][0].addr);
            void'(pq[k].pop_front());
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 0; wr = 0; hr = 0; hw = 0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hr = 1; hw = 1; ha = a; hd = d;
    tick();
    idle();
  endtask

  initial begin
    srstn = 0; idle();
    ra = '0; wa = '0; ha = '0; wd = '0; hd = '0;
    repeat (2) tick();
    srstn = 1;
    check("reset_rd_count", d_rc[0], 32'd0);
    check("reset_dram_valid", 32'(d_vld[1]), 32'd0);

    // host write then readback
    host_wr(18'd65536, 32'hA5A5_0001);
    hr = 1; hw = 0; ha = 18'd65536;
    #1 check("t1_gnt", 32'(d_gnt[0]), 32'd1);
    tick(); idle();
    check("t1_rvalid", 32'(d_hv[0]), 32'd1);
    check("t1_rdata", d_hrd[0], 32'hA5A5_0001);
    check("t1_rd_count", d_rc[0], 32'd0);

    host_wr(18'd0, 32'd10);
    host_wr(18'd1, 32'd11);
    host_wr(18'd2, 32'd12);
    host_wr(18'd3, 32'd13);
    host_wr(18'd131072, 32'd5);
    host_wr(18'd7, 32'd1);
    host_wr(18'h3FFFF, 32'h0BAD_F00D);

    // back-to-back reads, latency 1
    for (int i = 0; i < 4; i++) begin
      rd = 1; ra = 18'(i);
      tick();
      check("t2_valid", 32'(d_vld[0]), 32'd1);
      check("t2_data", d_rd[0], 32'(10 + i));
    end
    idle(); tick();
    check("t2_bubble", 32'(d_vld[0]), 32'd0);
    check("t2_hold", d_rd[0], 32'd13);
    check("t2_rd_count", d_rc[0], 32'd4);
    repeat (3) tick();

    // psum read / write-next-cycle
    rd = 1; ra = 18'd131072;
    tick();
    check("t3_first", d_rd[0], 32'd5);
    rd = 1; ra = 18'd131072; wr = 1; wa = 18'd131072; wd = 32'd9;
    tick(); idle();
    check("t3_second", d_rd[0], 32'd9);
    repeat (3) tick();

    // latency 3: write at t+2 forwards, write at t+3 does not
    rd = 1; ra = 18'd7;
    tick(); idle(); tick();
    wr = 1; wa = 18'd7; wd = 32'd42;
    tick(); idle();
    check("t4_fwd_valid", 32'(d_vld[1]), 32'd1);
    check("t4_fwd_data", d_rd[1], 32'd42);
    host_wr(18'd7, 32'd1);
    rd = 1; ra = 18'd7;
    tick(); idle(); tick(); tick();
    check("t4_late_data", d_rd[1], 32'd1);
    wr = 1; wa = 18'd7; wd = 32'd42;
    tick(); idle();

    // top address
    rd = 1; ra = 18'h3FFFF;
    tick(); idle();
    check("top_addr", d_rd[0], 32'h0BAD_F00D);
    repeat (3) tick();

    // host read held off by an engine burst
    hr = 1; hw = 0; ha = 18'd65536;
    for (int i = 0; i < 5; i++) begin
      rd = 1; ra = 18'(i % 4);
      #1 check("t5_no_gnt", 32'(d_gnt[0]), 32'd0);
      tick();
    end
    rd = 0;
    #1 check("t5_gnt", 32'(d_gnt[0]), 32'd1);
    tick(); hr = 0;
    check("t5_rvalid", 32'(d_hv[0]), 32'd1);
    check("t5_rdata", d_hrd[0], 32'hA5A5_0001);
    repeat (3) tick();

    // reset with two reads in flight on the latency-3 instance
    rd = 1; ra = 18'd0; tick();
    ra = 18'd1; tick();
    rd = 0; srstn = 0; wr = 1; wa = 18'd2; wd = 32'd99;
    tick();
    srstn = 1; idle();
    check("t6_valid", 32'(d_vld[1]), 32'd0);
    check("t6_data", d_rd[1], 32'd0);
    check("t6_rd_count", d_rc[1], 32'd0);
    check("t6_wr_count", d_wc[1], 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_return", 32'(d_vld[1]), 32'd0);
    end
    hr = 1; hw = 0; ha = 18'd2;
    tick(); idle();
    check("t6_mem_kept", d_hrd[1], 32'd12);
    hr = 1; hw = 0; ha = 18'h3FFFF;
    tick(); idle();
    check("t6_mem_top", d_hrd[1], 32'h0BAD_F00D);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
